// File: rtl/cp0_defs.sv
// rtl/cp0_defs.sv - CP0 register numbers, exception codes, write masks and excepttype decode
package cp0_defs;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    localparam logic [31:0] EXC_INT      = 32'h01;
    localparam logic [31:0] EXC_ADEL     = 32'h04;
    localparam logic [31:0] EXC_ADES     = 32'h05;
    localparam logic [31:0] EXC_SYS      = 32'h08;
    localparam logic [31:0] EXC_BP       = 32'h09;
    localparam logic [31:0] EXC_RI       = 32'h0a;
    localparam logic [31:0] EXC_CPU      = 32'h0b;
    localparam logic [31:0] EXC_OV       = 32'h0c;
    localparam logic [31:0] EXC_TRAP     = 32'h0d;
    localparam logic [31:0] EXC_ERET     = 32'h0e;
    localparam logic [31:0] EXC_TLBL_I   = 32'h10;
    localparam logic [31:0] EXC_TLBL_D   = 32'h11;
    localparam logic [31:0] EXC_TLBL_INV = 32'h12;
    localparam logic [31:0] EXC_TLBS     = 32'h13;
    localparam logic [31:0] EXC_TLB_MOD  = 32'h14;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_MOD  = 5'd1;
    localparam logic [4:0] CODE_TLBL = 5'd2;
    localparam logic [4:0] CODE_TLBS = 5'd3;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_CPU  = 5'd11;
    localparam logic [4:0] CODE_OV   = 5'd12;
    localparam logic [4:0] CODE_TR   = 5'd13;

    localparam logic [31:0] STATUS_WMASK = 32'h0040FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h00000300;
    localparam logic [31:0] STATUS_RESET = 32'h00400000;

    typedef struct packed {
        logic       valid;
        logic       bad_addr;
        logic [4:0] code;
    } exc_info_t;

    // eret and unknown codes come back invalid; eret is handled separately by the caller
    function automatic exc_info_t decode_exc(input logic [31:0] t);
        exc_info_t r;
        r = '{valid: 1'b1, bad_addr: 1'b0, code: CODE_INT};
        case (t)
            EXC_INT:      r.code = CODE_INT;
            EXC_ADEL:     begin r.code = CODE_ADEL; r.bad_addr = 1'b1; end
            EXC_ADES:     begin r.code = CODE_ADES; r.bad_addr = 1'b1; end
            EXC_SYS:      r.code = CODE_SYS;
            EXC_BP:       r.code = CODE_BP;
            EXC_RI:       r.code = CODE_RI;
            EXC_CPU:      r.code = CODE_CPU;
            EXC_OV:       r.code = CODE_OV;
            EXC_TRAP:     r.code = CODE_TR;
            EXC_TLBL_I,
            EXC_TLBL_D,
            EXC_TLBL_INV: begin r.code = CODE_TLBL; r.bad_addr = 1'b1; end
            EXC_TLBS:     begin r.code = CODE_TLBS; r.bad_addr = 1'b1; end
            EXC_TLB_MOD:  begin r.code = CODE_MOD;  r.bad_addr = 1'b1; end
            default:      r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with half-rate count and sticky timer interrupt
module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic toggle;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            toggle      <= 1'b0;
            count_o     <= '0;
            compare_o   <= '0;
            timer_int_o <= 1'b0;
        end else begin
            if (count_we_i) begin
                count_o <= wdata_i;
                toggle  <= 1'b0;
            end else begin
                toggle <= ~toggle;
                if (toggle)
                    count_o <= count_o + 32'd1;
            end

            if (compare_we_i)
                compare_o <= wdata_i;

            // Compare==0 is treated as "timer disarmed"
            if (compare_we_i)
                timer_int_o <= 1'b0;
            else if (compare_o != '0 && count_o == compare_o)
                timer_int_o <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - CP0 register file and exception commit; CP0_CONFIG_EN adds PRId/Config
module cp0_regfile
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h00004220,
    parameter logic [31:0] CONFIG_VAL = 32'h80000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

`ifdef CP0_CONFIG_EN
    localparam logic CFG_EN = 1'b1;
`else
    localparam logic CFG_EN = 1'b0;
`endif

    exc_info_t   exc;
    logic        is_eret;
    logic        mtc0_en;
    logic [31:0] status_wval;
    logic [31:0] cause_wval;

    assign exc         = decode_exc(excepttype_i);
    assign is_eret     = (excepttype_i == EXC_ERET);
    // any nonzero excepttype (even an unknown one) blocks the mtc0 write
    assign mtc0_en     = we_i && (excepttype_i == '0);
    assign status_wval = (status_o & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
    assign cause_wval  = (cause_o & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);

    cp0_timer u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .count_we_i   (mtc0_en && waddr_i == CP0_COUNT),
        .compare_we_i (mtc0_en && waddr_i == CP0_COMPARE),
        .wdata_i      (data_i),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .timer_int_o  (timer_int_o)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_o   <= STATUS_RESET;
            cause_o    <= '0;
            epc_o      <= '0;
            badvaddr_o <= '0;
        end else begin
            cause_o[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]};

            if (exc.valid) begin
                status_o[1]  <= 1'b1;
                cause_o[6:2] <= exc.code;
                // nested exception keeps the original return address and BD
                if (!status_o[1]) begin
                    epc_o       <= is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                     : current_inst_addr_i;
                    cause_o[31] <= is_in_delayslot_i;
                end
                if (exc.bad_addr)
                    badvaddr_o <= bad_addr_i;
            end else if (is_eret) begin
                status_o[1] <= 1'b0;
            end else if (mtc0_en) begin
                case (waddr_i)
                    CP0_STATUS: status_o      <= status_wval;
                    CP0_CAUSE:  cause_o[9:8]  <= data_i[9:8];
                    CP0_EPC:    epc_o         <= data_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (raddr_i)
            CP0_BADVADDR: data_o = badvaddr_o;
            CP0_COUNT:    data_o = count_o;
            CP0_COMPARE:  data_o = compare_o;
            CP0_STATUS:   data_o = status_o;
            CP0_CAUSE:    data_o = cause_o;
            CP0_EPC:      data_o = epc_o;
            CP0_PRID:     data_o = CFG_EN ? PRID_VAL : '0;
            CP0_CONFIG:   data_o = CFG_EN ? CONFIG_VAL : '0;
            default:      data_o = '0;
        endcase
        if (we_i && waddr_i == raddr_i) begin
            case (waddr_i)
                CP0_COUNT,
                CP0_COMPARE,
                CP0_EPC:    data_o = data_i;
                CP0_STATUS: data_o = status_wval;
                CP0_CAUSE:  data_o = cause_wval;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- MIPS CP0 register file and exception-commit stage. It sits directly downstream of the exception prioritiser and consumes its 32-bit excepttype word in the memory stage.
- On an exception it updates Status/Cause/EPC/BadVAddr. It also services mtc0/mfc0 and runs the Count/Compare timer interrupt.
- Its Status/Cause outputs feed back to the prioritiser's interrupt check.

Parameters:
- PRID_VAL, 32'h00004220, read-only PRId value (used only with the optional feature)
- CONFIG_VAL, 32'h80000000, read-only Config value (used only with the optional feature)

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- we_i  in  1  mtc0 write enable (memory stage)
- waddr_i  in  5  mtc0 destination register number
- raddr_i  in  5  mfc0 source register number
- data_i  in  32  mtc0 write data
- int_i  in  6  external hardware interrupts, level
- excepttype_i  in  32  encoded exception from the prioritiser; 0 = none
- current_inst_addr_i  in  32  PC of the excepting instruction
- is_in_delayslot_i  in  1  excepting instruction is in a delay slot
- bad_addr_i  in  32  faulting virtual address
- data_o  out  32  mfc0 read data
- count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  out  32 each  architectural registers
- timer_int_o  out  1  timer interrupt pending

Behaviour:
- Reset (resetn low, async)
  - Count=0, Compare=0, EPC=0, BadVAddr=0, Cause=0.
  - Status=32'h00400000 (BEV=1, EXL=0, IE=0, IM=0).
  - Tick toggle=0, timer_int_o=0.
  - Reset mid-exception discards everything; there is no partial update.
- Register numbers: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14.
- Count
  - Increments by 1 every second clk. An internal toggle flips each cycle; Count increments when toggle=1.
  - Wraps 32'hFFFFFFFF -> 0 with no flag.
- Timer interrupt
  - Compare!=0 and Count==Compare sets timer_int_o on the next edge.
  - timer_int_o is sticky and is cleared only by an mtc0 write to Compare.
- Cause.IP
  - Cause[15:10] <= {int_i[5]|timer_int_o, int_i[4:0]} every cycle, registered.
  - Cause[9:8] are software-writable.
- mtc0 (we_i=1, excepttype_i==0)
  - Count: full write; toggle cleared.
  - Compare: full write; timer_int cleared.
  - Status: only bits 22, 15:8, 1, 0.
  - Cause: only bits 9:8.
  - EPC: full write.
  - BadVAddr and other addresses: ignored.
  - Update takes effect next cycle.
- mfc0
  - data_o is combinational on raddr_i.
  - If we_i and waddr_i==raddr_i, data_o returns the post-mask write value (forwarding).
  - Unmapped addresses read 0.
- Exception commit (excepttype_i!=0, not 32'h0e)
  - The same-cycle mtc0 write is suppressed, but Count still ticks.
  - If Status.EXL==0: EPC <= is_in_delayslot_i ? current_inst_addr_i-4 : current_inst_addr_i, and Cause.BD <= is_in_delayslot_i.
  - If EXL==1: EPC and BD are unchanged.
  - Always: EXL <= 1 and Cause[6:2] <= ExcCode.
- ExcCode map (excepttype -> ExcCode):
  - 01->0, 04->4, 05->5, 08->8, 09->9, 0a->10, 0b->11, 0c->12, 0d->13
  - 10->2, 11->2, 12->2, 13->3, 14->1
  - Any other value: no register update.
- BadVAddr <= bad_addr_i for 04, 05 and 10..14.
- eret (32'h0e): Status.EXL <= 0 only; the mtc0 write is suppressed.
- Simultaneous events
  - Exception plus Compare match: both take effect.
  - Exception plus mtc0 Compare: the write is dropped, so timer_int is not cleared.

Optional Feature:
- CP0_CONFIG_EN defined
  - Adds read-only PRId (15, =PRID_VAL) and Config (16, =CONFIG_VAL).
  - Writes to them are ignored.
- CP0_CONFIG_EN undefined: addresses 15/16 read 0. No other difference.

Decomposition:
- Package cp0_defs holds:
  - Register-number constants (CP0_BADVADDR..CP0_CONFIG).
  - excepttype code constants (EXC_INT=32'h01 ... EXC_TLB_MOD=32'h14).
  - ExcCode constants.
  - Status/Cause write masks.
- Sub-module cp0_timer contains Count, the toggle, Compare and timer_int, with load/clear inputs from the parent.

Test Plan:
- Reset release, idle 10 cycles -> Count==5, Status==32'h00400000, all other outputs 0.
- mtc0 Compare=20, Count=10 -> timer_int_o rises when Count reaches 20 (about 20 cycles later) and stays high; mtc0 Compare=100 -> timer_int_o=0 next cycle.
- excepttype_i=32'h0c, PC=32'hBFC00100, delayslot=1, EXL=0 -> EPC=32'hBFC000FC, Cause.BD=1, ExcCode=12, EXL=1.
- Second exception 32'h04 with EXL=1, bad_addr=32'h00000003 -> EPC unchanged, ExcCode=4, BadVAddr=32'h00000003.
- Same cycle: we_i to EPC=32'h1234 plus excepttype_i=32'h08 -> EPC holds the PC, not 32'h1234; then eret -> EXL=0, EPC unchanged.
- mfc0 of Status concurrent with mtc0 Status=32'hFFFFFFFF -> data_o=32'h0040FF03; address 15 reads PRID_VAL only with CP0_CONFIG_EN defined.
